// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control bundle types and halt FSM states for the pipelined control path.
package ctrl_pkg;

  localparam int unsigned OPCODE_W     = 7;
  localparam int unsigned DRAIN_CNT_W  = 4;
  localparam int unsigned ALUOP_BASE_W = 2;
  localparam int unsigned MEMTOREG_W   = 2;

  localparam logic [OPCODE_W-1:0] R_TYPE = 7'b0110011;
  localparam logic [OPCODE_W-1:0] I_TYPE = 7'b0010011;
  localparam logic [OPCODE_W-1:0] LW     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] SW     = 7'b0100011;
  localparam logic [OPCODE_W-1:0] BR     = 7'b1100011;
  localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] HALT   = 7'b1111111;
  localparam logic [OPCODE_W-1:0] LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] AUIPC  = 7'b0010111;

  localparam logic [ALUOP_BASE_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_BASE_W-1:0] ALUOP_BR    = 2'b01;
  localparam logic [ALUOP_BASE_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_BASE_W-1:0] ALUOP_JALR  = 2'b11;

  localparam logic [MEMTOREG_W-1:0] WB_ALU = 2'b00;
  localparam logic [MEMTOREG_W-1:0] WB_MEM = 2'b01;
  localparam logic [MEMTOREG_W-1:0] WB_PC4 = 2'b10;
  localparam logic [MEMTOREG_W-1:0] WB_UIM = 2'b11;

  // ALUOp travels beside the bundle because its width is a per-instance parameter.
  typedef struct packed {
    logic                  alu_src;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  u_type;
    logic                  pc_rel;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic                  illegal;
    logic                  halt;
  } ctrl_bundle_t;

  typedef struct packed {
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [MEMTOREG_W-1:0] mem_to_reg;
    logic                  halt;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  reg_write;
    logic [MEMTOREG_W-1:0] mem_to_reg;
  } wb_ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } halt_state_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;
  localparam mem_ctrl_t    MEM_BUBBLE  = '0;
  localparam wb_ctrl_t     WB_BUBBLE   = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an RV32 opcode onto the control bundle and ALUOp.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_U_TYPE = 1,
  parameter int unsigned ALUOP_W    = 2
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_bundle_t        ctrl_c,
  output logic [ALUOP_W-1:0]  alu_op_c
);

  logic [ALUOP_BASE_W-1:0] alu_base_c;

  always_comb begin
    ctrl_c     = CTRL_BUBBLE;
    alu_base_c = ALUOP_ADD;
    unique case (opcode)
      R_TYPE: begin
        ctrl_c.reg_write = 1'b1;
        alu_base_c       = ALUOP_FUNCT;
      end
      I_TYPE: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        alu_base_c       = ALUOP_FUNCT;
      end
      LW: begin
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_MEM;
      end
      SW: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
      end
      BR: begin
        ctrl_c.branch = 1'b1;
        alu_base_c    = ALUOP_BR;
      end
      JAL: begin
        ctrl_c.jal        = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_PC4;
      end
      JALR: begin
        ctrl_c.jalr       = 1'b1;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = WB_PC4;
        alu_base_c        = ALUOP_JALR;
      end
      HALT: ctrl_c.halt = 1'b1;
      LUI, AUIPC: begin
        if (EXT_U_TYPE != 0) begin
          ctrl_c.alu_src    = 1'b1;
          ctrl_c.reg_write  = 1'b1;
          ctrl_c.mem_to_reg = WB_UIM;
          ctrl_c.u_type     = 1'b1;
          ctrl_c.pc_rel     = (opcode == AUIPC);
        end else begin
          ctrl_c.illegal = 1'b1;
        end
      end
      default: ctrl_c.illegal = 1'b1;
    endcase
  end

  // Wider ALUOp fields zero-extend the two-bit base encoding.
  assign alu_op_c = ALUOP_W'(alu_base_c);

endmodule

// File: rtl/control_pipe.sv
// Pipelined control path: decode in ID, carry controls through ID/EX, EX/MEM, MEM/WB,
// with stall bubbles, branch flush and a halt drain state machine.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned EXT_U_TYPE   = 1,
  parameter int unsigned DRAIN_CYCLES = 1,
  parameter int unsigned ALUOP_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic                  id_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  fetch_en,
  output logic                  ex_ALUSrc,
  output logic                  ex_Branch,
  output logic                  ex_Jal,
  output logic                  ex_Jalr,
  output logic                  ex_UType,
  output logic                  ex_PcRel,
  output logic [ALUOP_W-1:0]    ex_ALUOp,
  output logic                  ex_illegal,
  output logic                  mem_MemRead,
  output logic                  mem_MemWrite,
  output logic                  wb_RegWrite,
  output logic [MEMTOREG_W-1:0] wb_MemtoReg,
  output logic                  halted
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_CNT_W-1:0] CNT_ONE    = DRAIN_CNT_W'(1);

  ctrl_bundle_t            dec_c;
  logic [ALUOP_W-1:0]      dec_alu_op_c;
  logic                    id_load_c;
  ctrl_bundle_t            id_ex;
  logic [ALUOP_W-1:0]      id_ex_alu_op;
  mem_ctrl_t               ex_mem;
  mem_ctrl_t               ex_mem_d_c;
  wb_ctrl_t                mem_wb;
  halt_state_t             state;
  halt_state_t             state_d;
  logic [DRAIN_CNT_W-1:0]  drain_cnt;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_d;

  ctrl_decode #(
    .EXT_U_TYPE (EXT_U_TYPE),
    .ALUOP_W    (ALUOP_W)
  ) u_decode (
    .opcode   (id_opcode),
    .ctrl_c   (dec_c),
    .alu_op_c (dec_alu_op_c)
  );

  // Only a live instruction, fetched while running and not stalled or flushed, enters EX.
  assign id_load_c = id_valid && !flush && !stall && (state == ST_RUN);

  always_comb begin
    ex_mem_d_c = MEM_BUBBLE;
    if (!flush) begin
      ex_mem_d_c.mem_read   = id_ex.mem_read;
      ex_mem_d_c.mem_write  = id_ex.mem_write;
      ex_mem_d_c.reg_write  = id_ex.reg_write;
      ex_mem_d_c.mem_to_reg = id_ex.mem_to_reg;
      ex_mem_d_c.halt       = id_ex.halt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex        <= CTRL_BUBBLE;
      id_ex_alu_op <= '0;
      ex_mem       <= MEM_BUBBLE;
      mem_wb       <= WB_BUBBLE;
    end else begin
      id_ex        <= id_load_c ? dec_c : CTRL_BUBBLE;
      id_ex_alu_op <= id_load_c ? dec_alu_op_c : '0;
      ex_mem       <= ex_mem_d_c;
      mem_wb       <= '{reg_write: ex_mem.reg_write, mem_to_reg: ex_mem.mem_to_reg};
    end
  end

  // Halt FSM state, drain counter and the registered fetch/halt indications.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      fetch_en  <= 1'b1;
      halted    <= 1'b0;
    end else begin
      state     <= state_d;
      drain_cnt <= drain_cnt_d;
      fetch_en  <= (state_d == ST_RUN);
      halted    <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    unique case (state)
      ST_RUN: begin
        if (id_load_c && dec_c.halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A flush reaching the HALT before it retires means it was on a wrong path.
        if (flush && (id_ex.halt || ex_mem.halt)) begin
          state_d = ST_RUN;
        end else if (ex_mem.halt) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_HALTED;
          end else begin
            state_d     = ST_WAIT;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end
      ST_WAIT: begin
        drain_cnt_d = drain_cnt - CNT_ONE;
        if (drain_cnt <= CNT_ONE) state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  assign ex_ALUSrc    = id_ex.alu_src;
  assign ex_Branch    = id_ex.branch;
  assign ex_Jal       = id_ex.jal;
  assign ex_Jalr      = id_ex.jalr;
  assign ex_UType     = id_ex.u_type;
  assign ex_PcRel     = id_ex.pc_rel;
  assign ex_ALUOp     = id_ex_alu_op;
  assign ex_illegal   = id_ex.illegal;
  assign mem_MemRead  = ex_mem.mem_read;
  assign mem_MemWrite = ex_mem.mem_write;
  assign wb_RegWrite  = mem_wb.reg_write;
  assign wb_MemtoReg  = mem_wb.mem_to_reg;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: per-edge scoreboard of stage controls plus targeted checks.
module tb_control_pipe;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b1111111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_ZERO = 7'b0000000;

  // Expected control record: ALUSrc Branch Jal Jalr UType PcRel | ALUOp | MemRead MemWrite RegWrite | MemtoReg | illegal halt
  typedef struct packed {
    logic       alu_src, branch, jal, jalr, u_type, pc_rel;
    logic [1:0] alu_op;
    logic       mem_read, mem_write, reg_write;
    logic [1:0] mem_to_reg;
    logic       illegal, halt;
  } dec_t;

  typedef struct {
    dec_t ex;
    dec_t mem;
    dec_t wb;
    logic fetch;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] id_opcode;
  logic       id_valid, stall, flush;

  logic       fetch_en, ex_ALUSrc, ex_Branch, ex_Jal, ex_Jalr, ex_UType, ex_PcRel, ex_illegal;
  logic [1:0] ex_ALUOp;
  logic       mem_MemRead, mem_MemWrite, wb_RegWrite, halted;
  logic [1:0] wb_MemtoReg;

  logic       u2_fetch_en, u2_ex_ALUSrc, u2_ex_Branch, u2_ex_Jal, u2_ex_Jalr, u2_ex_UType, u2_ex_PcRel, u2_ex_illegal;
  logic [2:0] u2_ex_ALUOp;
  logic       u2_mem_MemRead, u2_mem_MemWrite, u2_wb_RegWrite, u2_halted;
  logic [1:0] u2_wb_MemtoReg;

  int   n_checks = 0;
  int   n_errors = 0;
  sb_t  sb_q[$];
  dec_t m_ex, m_mem, m_wb;
  logic m_run, m_lock;

  always #5 clk = ~clk;

  control_pipe #(.EXT_U_TYPE(1), .DRAIN_CYCLES(1), .ALUOP_W(2)) dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid), .stall(stall), .flush(flush),
    .fetch_en(fetch_en), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_Jal(ex_Jal), .ex_Jalr(ex_Jalr),
    .ex_UType(ex_UType), .ex_PcRel(ex_PcRel), .ex_ALUOp(ex_ALUOp), .ex_illegal(ex_illegal),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .halted(halted)
  );

  control_pipe #(.EXT_U_TYPE(0), .DRAIN_CYCLES(0), .ALUOP_W(3)) dut_nu (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_valid(id_valid), .stall(stall), .flush(flush),
    .fetch_en(u2_fetch_en), .ex_ALUSrc(u2_ex_ALUSrc), .ex_Branch(u2_ex_Branch), .ex_Jal(u2_ex_Jal),
    .ex_Jalr(u2_ex_Jalr), .ex_UType(u2_ex_UType), .ex_PcRel(u2_ex_PcRel), .ex_ALUOp(u2_ex_ALUOp),
    .ex_illegal(u2_ex_illegal), .mem_MemRead(u2_mem_MemRead), .mem_MemWrite(u2_mem_MemWrite),
    .wb_RegWrite(u2_wb_RegWrite), .wb_MemtoReg(u2_wb_MemtoReg), .halted(u2_halted)
  );

  function automatic dec_t ref_dec(input logic [6:0] op);
    logic [14:0] v;
    case (op)
      OP_R:    v = 15'b000000_10_001_00_00;
      OP_I:    v = 15'b100000_10_001_00_00;
      OP_LW:   v = 15'b100000_00_101_01_00;
      OP_SW:   v = 15'b100000_00_010_00_00;
      OP_BR:   v = 15'b010000_01_000_00_00;
      OP_JAL:  v = 15'b001000_00_001_10_00;
      OP_JALR: v = 15'b100100_11_001_10_00;
      OP_HALT: v = 15'b000000_00_000_00_01;
      OP_LUI:  v = 15'b100010_00_001_11_00;
      OP_AUI:  v = 15'b100011_00_001_11_00;
      default: v = 15'b000000_00_000_00_10;
    endcase
    return dec_t'(v);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_run = 1'b1; m_lock = 1'b0;
  endtask

  // Drive one ID cycle, push the expected post-edge stage contents, then compare after the edge.
  task automatic step(input logic [6:0] op, input logic vld, input logic stl, input logic fl);
    dec_t d;
    logic ld, n_run, n_lock;
    sb_t  r;
    id_opcode = op; id_valid = vld; stall = stl; flush = fl;
    d      = ref_dec(op);
    ld     = m_run && !fl && !stl && vld;
    n_run  = m_run;
    n_lock = m_lock;
    if (m_run) begin
      if (ld && d.halt) n_run = 1'b0;
    end else if (!m_lock) begin
      if (fl && (m_ex.halt || m_mem.halt)) n_run = 1'b1;
      else if (m_mem.halt) n_lock = 1'b1;
    end
    m_wb   = m_mem;
    m_mem  = fl ? dec_t'(0) : m_ex;
    m_ex   = ld ? d : dec_t'(0);
    m_run  = n_run;
    m_lock = n_lock;
    r.ex = m_ex; r.mem = m_mem; r.wb = m_wb; r.fetch = m_run;
    sb_q.push_back(r);
    @(posedge clk);
    #1;
    r = sb_q.pop_front();
    check("ex_stage", 16'({ex_ALUSrc, ex_Branch, ex_Jal, ex_Jalr, ex_UType, ex_PcRel, ex_ALUOp, ex_illegal}),
          16'({r.ex.alu_src, r.ex.branch, r.ex.jal, r.ex.jalr, r.ex.u_type, r.ex.pc_rel, r.ex.alu_op, r.ex.illegal}));
    check("mem_stage", 16'({mem_MemRead, mem_MemWrite}), 16'({r.mem.mem_read, r.mem.mem_write}));
    check("wb_stage", 16'({wb_RegWrite, wb_MemtoReg}), 16'({r.wb.reg_write, r.wb.mem_to_reg}));
    check("fetch_en", 16'(fetch_en), 16'(r.fetch));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(OP_ZERO, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    id_opcode = OP_ZERO; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; id_opcode = OP_ZERO; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    mdl_reset();
    @(negedge clk);
    check("rst_fetch_en", 16'(fetch_en), 16'd1);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_ex", 16'({ex_ALUSrc, ex_Branch, ex_Jal, ex_Jalr, ex_UType, ex_PcRel, ex_ALUOp, ex_illegal}), 16'd0);
    check("rst_wb", 16'({wb_RegWrite, wb_MemtoReg}), 16'd0);
    reset = 1'b0;

    // R-type latency to EX and WB
    step(OP_R, 1'b1, 1'b0, 1'b0);
    check("r_ex_aluop", 16'(ex_ALUOp), 16'b10);
    check("r_ex_alusrc", 16'(ex_ALUSrc), 16'd0);
    check("r_wide_aluop", 16'(u2_ex_ALUOp), 16'b010);
    idle(2);
    check("r_wb", 16'({wb_RegWrite, wb_MemtoReg}), 16'b100);

    // load followed by a one-cycle stall bubble
    step(OP_LW, 1'b1, 1'b0, 1'b0);
    step(OP_I, 1'b1, 1'b1, 1'b0);
    check("stall_bubble_ex", 16'({ex_ALUSrc, ex_ALUOp, ex_illegal}), 16'd0);
    check("lw_mem_read", 16'(mem_MemRead), 16'd1);
    step(OP_I, 1'b1, 1'b0, 1'b0);
    step(OP_JALR, 1'b1, 1'b0, 1'b0);
    check("jalr_ex_aluop", 16'(ex_ALUOp), 16'b11);

    // JAL, SW, BR back to back; flush together with stall while BR is in ID
    step(OP_JAL, 1'b1, 1'b0, 1'b0);
    step(OP_SW, 1'b1, 1'b0, 1'b0);
    step(OP_BR, 1'b1, 1'b1, 1'b1);
    check("flush_sw_killed", 16'(mem_MemWrite), 16'd0);
    check("jal_wb_memtoreg", 16'(wb_MemtoReg), 16'b10);
    idle(3);

    // HALT drain: SW ahead still writes, second HALT is dropped
    step(OP_SW, 1'b1, 1'b0, 1'b0);
    step(OP_HALT, 1'b1, 1'b0, 1'b0);
    check("halt_fetch_off", 16'(fetch_en), 16'd0);
    check("halt_sw_write", 16'(mem_MemWrite), 16'd1);
    step(OP_HALT, 1'b1, 1'b0, 1'b0);
    check("halt_k1_halted", 16'(halted), 16'd0);
    step(OP_R, 1'b1, 1'b0, 1'b0);
    check("halt_k2_halted", 16'(halted), 16'd0);
    check("halt_k2_nodrain", 16'(u2_halted), 16'd1);
    step(OP_R, 1'b1, 1'b0, 1'b0);
    check("halt_k3_halted", 16'(halted), 16'd1);
    step(OP_R, 1'b1, 1'b1, 1'b1);
    check("halted_sticky", 16'({halted, fetch_en}), 16'b10);
    idle(2);
    do_reset();

    // speculative HALT squashed by a flush while in ID/EX
    step(OP_HALT, 1'b1, 1'b0, 1'b0);
    check("spec_halt_fetch", 16'(fetch_en), 16'd0);
    step(OP_ZERO, 1'b0, 1'b0, 1'b1);
    check("squash_fetch_on", 16'(fetch_en), 16'd1);
    idle(4);
    check("squash_no_halt", 16'({halted, u2_halted}), 16'd0);

    // U-type and illegal decode
    step(OP_LUI, 1'b1, 1'b0, 1'b0);
    check("nou_lui_illegal", 16'({u2_ex_ALUSrc, u2_ex_Branch, u2_ex_Jal, u2_ex_Jalr, u2_ex_UType, u2_ex_PcRel,
                                  u2_ex_ALUOp, u2_ex_illegal}), 16'd1);
    step(OP_AUI, 1'b1, 1'b0, 1'b0);
    check("aui_pcrel", 16'({ex_UType, ex_PcRel, ex_illegal}), 16'b110);
    step(OP_ZERO, 1'b1, 1'b0, 1'b0);
    check("zero_illegal", 16'({ex_ALUSrc, ex_Branch, ex_Jal, ex_Jalr, ex_UType, ex_PcRel, ex_ALUOp, ex_illegal}),
          16'd1);
    check("lui_wb_memtoreg", 16'({wb_RegWrite, wb_MemtoReg}), 16'b111);
    check("nou_zero_illegal", 16'(u2_ex_illegal), 16'd1);
    idle(3);

    // asynchronous reset while the drain counter is running
    step(OP_HALT, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("wait_pre_state", 16'({fetch_en, halted, u2_halted}), 16'b001);
    reset = 1'b1;
    #1;
    check("async_rst_fetch", 16'(fetch_en), 16'd1);
    check("async_rst_halted", 16'({halted, u2_halted}), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    step(OP_I, 1'b1, 1'b0, 1'b0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
